// File: rtl/lcd_ctrl_param_if.sv
// Command/ROM/RAM bundle of the parametrised LCD controller.
// slave is the controller side, master is the host plus the IROM/IRAM macros.
interface lcd_ctrl_param_if #(
   parameter int DW = 8,
   parameter int AW = 6
);
   logic [3:0]    cmd;
   logic          cmd_valid;
   logic [DW-1:0] IROM_Q;
   logic          IROM_rd;
   logic [AW-1:0] IROM_A;
   logic          IRAM_valid;
   logic [DW-1:0] IRAM_D;
   logic [AW-1:0] IRAM_A;
   logic          busy;
   logic          done;
   logic [2:0]    dbg_state;

   // cmd is taken only on a cycle where cmd_valid=1 and busy=0; it is never queued.
   modport slave (
      input  cmd, cmd_valid, IROM_Q,
      output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done, dbg_state
   );
   modport master (
      output cmd, cmd_valid, IROM_Q,
      input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done, dbg_state
   );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Parametrised image controller: loads IMG_W x IMG_H pixels from IROM, runs 2x2
// window commands around a movable origin, then streams the image to IRAM.
module lcd_ctrl_param #(
   parameter  int DW    = 8,
   parameter  int IMG_W = 8,
   parameter  int IMG_H = 8,
   localparam int XW    = $clog2(IMG_W),
   localparam int YW    = $clog2(IMG_H),
   localparam int AW    = XW + YW,
   localparam int N     = IMG_W * IMG_H
) (
   input logic           clk,
   input logic           reset,
   lcd_ctrl_param_if.slave bus
);
   typedef enum logic [2:0] {S_LOAD, S_WAIT, S_EXEC, S_WRITE, S_DONE} state_t;

   localparam logic [AW-1:0] LAST  = AW'(N - 1);
   localparam logic [XW-1:0] X_MID = XW'(IMG_W / 2);
   localparam logic [YW-1:0] Y_MID = YW'(IMG_H / 2);

   state_t        state_q, state_d;
   logic [AW-1:0] rom_a_q, rom_a_d;
   logic          rom_rd_q, rom_rd_d;
   logic          ld_vld_q, ld_vld_d;
   logic [AW-1:0] ld_addr_q, ld_addr_d;
   logic          iram_vld_q, iram_vld_d;
   logic [AW-1:0] iram_a_q, iram_a_d;
   logic [DW-1:0] iram_dat_q, iram_dat_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [3:0]    op_q, op_d;
   logic [DW-1:0] img_q [N];
   logic [DW-1:0] img_d [N];

   logic [XW-1:0] xm;
   logic [YW-1:0] ym;
   logic [AW-1:0] a0, a1, a2, a3, nxt_a;
   logic [DW-1:0] p0, p1, p2, p3, m01, m23, n01, n23, mx, mn, avg;
   logic [DW+1:0] sum;

   // Window around the origin: P0 top-left, P1 top-right, P2 bottom-left, P3 bottom-right.
   assign xm    = x_q - XW'(1);
   assign ym    = y_q - YW'(1);
   assign a0    = {ym, xm};
   assign a1    = {ym, x_q};
   assign a2    = {y_q, xm};
   assign a3    = {y_q, x_q};
   assign nxt_a = iram_a_q + AW'(1);
   assign p0    = img_q[a0];
   assign p1    = img_q[a1];
   assign p2    = img_q[a2];
   assign p3    = img_q[a3];
   assign m01   = (p0 > p1) ? p0 : p1;
   assign m23   = (p2 > p3) ? p2 : p3;
   assign mx    = (m01 > m23) ? m01 : m23;
   assign n01   = (p0 < p1) ? p0 : p1;
   assign n23   = (p2 < p3) ? p2 : p3;
   assign mn    = (n01 < n23) ? n01 : n23;
   assign sum   = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
   assign avg   = sum[DW+1:2];

   always_comb begin
      state_d    = state_q;
      rom_a_d    = rom_a_q;
      rom_rd_d   = rom_rd_q;
      ld_vld_d   = ld_vld_q;
      ld_addr_d  = ld_addr_q;
      iram_vld_d = iram_vld_q;
      iram_a_d   = iram_a_q;
      iram_dat_d = iram_dat_q;
      busy_d     = busy_q;
      done_d     = done_q;
      x_d        = x_q;
      y_d        = y_q;
      op_d       = op_q;
      img_d      = img_q;
      case (state_q)
         S_LOAD: begin
            // ROM data arrives one cycle after its address, so the store trails the fetch.
            if (ld_vld_q) img_d[ld_addr_q] = bus.IROM_Q;
            ld_vld_d  = rom_rd_q;
            ld_addr_d = rom_a_q;
            if (rom_rd_q) begin
               if (rom_a_q == LAST) rom_rd_d = 1'b0;
               else                 rom_a_d  = rom_a_q + AW'(1);
            end
            if (ld_vld_q && ld_addr_q == LAST) begin
               state_d = S_WAIT;
               busy_d  = 1'b0;
            end
         end
         S_WAIT: begin
            if (bus.cmd_valid) begin
               busy_d = 1'b1;
               if (bus.cmd == 4'h0) begin
                  state_d    = S_WRITE;
                  iram_vld_d = 1'b1;
                  iram_a_d   = '0;
                  iram_dat_d = img_q[0];
               end else begin
                  state_d = S_EXEC;
                  op_d    = bus.cmd;
               end
            end
         end
         S_EXEC: begin
            state_d = S_WAIT;
            busy_d  = 1'b0;
            case (op_q)
               4'h1: if (y_q > YW'(1)) y_d = ym;
               4'h2: if (y_q != YW'(IMG_H - 1)) y_d = y_q + YW'(1);
               4'h3: if (x_q > XW'(1)) x_d = xm;
               4'h4: if (x_q != XW'(IMG_W - 1)) x_d = x_q + XW'(1);
               4'h5: begin img_d[a0] = mx;  img_d[a1] = mx;  img_d[a2] = mx;  img_d[a3] = mx;  end
               4'h6: begin img_d[a0] = mn;  img_d[a1] = mn;  img_d[a2] = mn;  img_d[a3] = mn;  end
               4'h7: begin img_d[a0] = avg; img_d[a1] = avg; img_d[a2] = avg; img_d[a3] = avg; end
               4'h8: begin img_d[a0] = p1;  img_d[a1] = p3;  img_d[a2] = p0;  img_d[a3] = p2;  end
               4'h9: begin img_d[a0] = p2;  img_d[a1] = p0;  img_d[a2] = p3;  img_d[a3] = p1;  end
               4'hA: begin img_d[a0] = p2;  img_d[a1] = p3;  img_d[a2] = p0;  img_d[a3] = p1;  end
               4'hB: begin img_d[a0] = p1;  img_d[a1] = p0;  img_d[a2] = p3;  img_d[a3] = p2;  end
               4'hC: begin img_d[a0] = ~p0; img_d[a1] = ~p1; img_d[a2] = ~p2; img_d[a3] = ~p3; end
               4'hD: begin x_d = X_MID; y_d = Y_MID; end
               default: ;
            endcase
         end
         S_WRITE: begin
            if (iram_a_q == LAST) begin
               iram_vld_d = 1'b0;
               done_d     = 1'b1;
               state_d    = S_DONE;
            end else begin
               iram_a_d   = nxt_a;
               iram_dat_d = img_q[nxt_a];
            end
         end
         S_DONE: ;
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_LOAD;
         rom_a_q    <= '0;
         rom_rd_q   <= 1'b1;
         ld_vld_q   <= 1'b0;
         ld_addr_q  <= '0;
         iram_vld_q <= 1'b0;
         iram_a_q   <= '0;
         iram_dat_q <= '0;
         busy_q     <= 1'b1;
         done_q     <= 1'b0;
         x_q        <= X_MID;
         y_q        <= Y_MID;
         op_q       <= '0;
         for (int i = 0; i < N; i++) img_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         rom_a_q    <= rom_a_d;
         rom_rd_q   <= rom_rd_d;
         ld_vld_q   <= ld_vld_d;
         ld_addr_q  <= ld_addr_d;
         iram_vld_q <= iram_vld_d;
         iram_a_q   <= iram_a_d;
         iram_dat_q <= iram_dat_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         x_q        <= x_d;
         y_q        <= y_d;
         op_q       <= op_d;
         img_q      <= img_d;
      end
   end

   assign bus.IROM_rd    = rom_rd_q;
   assign bus.IROM_A     = rom_a_q;
   assign bus.IRAM_valid = iram_vld_q;
   assign bus.IRAM_A     = iram_a_q;
   assign bus.IRAM_D     = iram_dat_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.dbg_state  = state_q;
endmodule
